branch_predictor: RTL and testbench
===================================

// Module: branch_predictor
// PURPOSE
//  Fetch-side producer of the branch prediction consumed by the execute stage. Direct-mapped
//  BTB + 2-bit saturating counters; looked up combinationally with PCF, prediction travels down
//  the pipe as Predict_branch. Trained by the execute stage's resolution (PCSrcE, PCTargetE,
//  Eval_branch). Also keeps saturating branch/mispredict performance counters.
// PARAMETERS
//  IDX_BITS   4   table index width; ENTRIES = 2**IDX_BITS; index = PC[IDX_BITS+1:2]
//  TAG_BITS   30-IDX_BITS (derived localparam, not overridable); tag = PC[31:IDX_BITS+2]
//  CNT_W      32  width of performance counters
// PORTS
//  clk             in   1      clock, rising edge
//  rst             in   1      reset, asynchronous, active-high
//  PCF             in   32     fetch PC to look up
//  PredictTakenF   out  1      1 = redirect fetch to PredictTargetF
//  PredictTargetF  out  32     predicted target (valid only when PredictTakenF=1)
//  UpdateE         in   1      execute holds a resolved branch/jump this cycle (BranchE|JumpE, not flushed)
//  JumpE           in   1      resolved instruction is an unconditional jump
//  PCE             in   32     PC of the resolved instruction
//  TakenE          in   1      actual direction (PCSrcE)
//  TargetE         in   32     actual taken target (adder output PCE+ImmExtE)
//  MispredictE     in   1      execute's Eval_branch: prediction was wrong, pipe redirected
//  StatClear       in   1      synchronous clear of both performance counters
//  BranchCount     out  CNT_W  number of UpdateE cycles seen
//  MispredictCount out  CNT_W  number of UpdateE cycles with MispredictE=1
// BEHAVIOUR
//  - Entry = {valid, tag[TAG_BITS], target[32], ctr[2]}. Reset: all valid=0, ctr=2'b01, target=0,
//    tag=0; BranchCount=MispredictCount=0. Outputs then read PredictTakenF=0, PredictTargetF=0.
//  - Lookup (combinational, 0 latency): hit = valid[i] & tag[i]==PCF tag.
//    PredictTakenF = hit & ctr[i][1]; PredictTargetF = hit ? target[i] : 32'b0.
//  - Update on posedge clk when UpdateE=1, index/tag from PCE:
//    * hit, JumpE=1: ctr<=2'b11, target<=TargetE.
//    * hit, TakenE=1: ctr<=sat_inc(ctr) (11 stays 11), target<=TargetE.
//    * hit, TakenE=0: ctr<=sat_dec(ctr) (00 stays 00); target and valid unchanged.
//    * miss, TakenE=1: allocate/replace: valid<=1, tag<=PCE tag, target<=TargetE,
//      ctr<= JumpE ? 2'b11 : 2'b10.
//    * miss, TakenE=0: no change (not-taken branches never allocate).
//  - UpdateE=0: table untouched regardless of other update inputs.
//  - Same-cycle lookup and update of the same entry: read-before-write; PredictTakenF/
//    PredictTargetF reflect pre-edge contents; new contents visible from next cycle.
//  - Entries are never invalidated except by rst; aliasing PCs with same index evict each other.
//  - Counters: on posedge, StatClear=1 -> both <=0 (clear wins over a simultaneous update).
//    Else if UpdateE: BranchCount+=1; MispredictCount+=MispredictE. Both saturate at all-ones.
//    MispredictE with UpdateE=0 is ignored.
//  - rst asserted mid-operation: table and counters return to reset state immediately
//    (asynchronously); first update accepted on the first clk edge after rst deasserts.
// TESTING
//  1 Reset, PCF=0x100 -> PredictTakenF=0, PredictTargetF=0, both counters 0.
//  2 Update PCE=0x100 Taken=1 Target=0x80 Jump=0; next cycle PCF=0x100 -> Taken=1, Target=0x80 (ctr=10).
//  3 Then 2x update PCE=0x100 Taken=0 -> after 1st ctr=01 PredictTakenF=0; after 2nd ctr=00;
//    3rd not-taken stays 00; 1 taken -> 01 still predicts not-taken; entry valid, target 0x80 kept.
//  4 Alias (IDX_BITS=4): allocate 0x100 then taken update PCE=0x140 Target=0x200 -> PCF=0x100
//    misses (Taken=0), PCF=0x140 hits Target=0x200; Jump update sets ctr=11 directly.
//  5 Same-cycle: PCF=PCE=0x300 first taken update -> that cycle PredictTakenF=0, next cycle 1.
//  6 10 updates with 3 MispredictE=1 -> BranchCount=10, MispredictCount=3; StatClear with UpdateE
//    same cycle -> both 0; force counters near max (CNT_W=4) -> hold at 15.

Source files
------------

// File: rtl/branch_predictor.sv
// Fetch-side branch predictor: direct-mapped BTB with 2-bit saturating direction counters,
// looked up combinationally from PCF and trained by the execute stage's branch resolution.
module branch_predictor #(
  parameter int IDX_BITS = 4,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      PCF,
  output logic             PredictTakenF,
  output logic [31:0]      PredictTargetF,
  input  logic             UpdateE,
  input  logic             JumpE,
  input  logic [31:0]      PCE,
  input  logic             TakenE,
  input  logic [31:0]      TargetE,
  input  logic             MispredictE,
  input  logic             StatClear,
  output logic [CNT_W-1:0] BranchCount,
  output logic [CNT_W-1:0] MispredictCount
);

  localparam int TAG_BITS = 30 - IDX_BITS;
  localparam int ENTRIES  = 2 ** IDX_BITS;

  // Training handshake: UpdateE is a one-cycle valid strobe with no ready; the predictor
  // always accepts it. PCE/TakenE/TargetE/JumpE/MispredictE are meaningful only while it is high.

  logic                valid_q  [ENTRIES];
  logic [TAG_BITS-1:0] tag_q    [ENTRIES];
  logic [31:0]         target_q [ENTRIES];
  logic [1:0]          ctr_q    [ENTRIES];

  logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0] mis_cnt_q, mis_cnt_d;

  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    return (c == 2'b11) ? c : c + 2'd1;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] c);
    return (c == 2'b00) ? c : c - 2'd1;
  endfunction

  // Fetch-side lookup
  logic [IDX_BITS-1:0] f_idx;
  logic [TAG_BITS-1:0] f_tag;
  logic                f_hit;

  assign f_idx = PCF[IDX_BITS+1:2];
  assign f_tag = PCF[31:IDX_BITS+2];
  assign f_hit = valid_q[f_idx] && (tag_q[f_idx] == f_tag);

  assign PredictTakenF  = f_hit && ctr_q[f_idx][1];
  assign PredictTargetF = f_hit ? target_q[f_idx] : 32'b0;

  // Execute-side training
  logic [IDX_BITS-1:0] e_idx;
  logic [TAG_BITS-1:0] e_tag;
  logic                e_hit;
  logic                upd_we;
  logic                valid_d;
  logic [TAG_BITS-1:0] tag_d;
  logic [31:0]         target_d;
  logic [1:0]          ctr_d;

  assign e_idx = PCE[IDX_BITS+1:2];
  assign e_tag = PCE[31:IDX_BITS+2];
  assign e_hit = valid_q[e_idx] && (tag_q[e_idx] == e_tag);

  always_comb begin
    upd_we   = 1'b0;
    valid_d  = valid_q[e_idx];
    tag_d    = tag_q[e_idx];
    target_d = target_q[e_idx];
    ctr_d    = ctr_q[e_idx];
    if (UpdateE) begin
      if (e_hit) begin
        upd_we = 1'b1;
        if (JumpE) begin
          ctr_d    = 2'b11;
          target_d = TargetE;
        end else if (TakenE) begin
          ctr_d    = sat_inc(ctr_q[e_idx]);
          target_d = TargetE;
        end else begin
          ctr_d = sat_dec(ctr_q[e_idx]);
        end
      end else if (TakenE) begin
        // Only taken resolutions allocate; a jump starts strongly taken.
        upd_we   = 1'b1;
        valid_d  = 1'b1;
        tag_d    = e_tag;
        target_d = TargetE;
        ctr_d    = JumpE ? 2'b11 : 2'b10;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= 32'b0;
        ctr_q[i]    <= 2'b01;
      end
    end else if (upd_we) begin
      valid_q[e_idx]  <= valid_d;
      tag_q[e_idx]    <= tag_d;
      target_q[e_idx] <= target_d;
      ctr_q[e_idx]    <= ctr_d;
    end
  end

  // Performance counters saturate at all-ones; clear takes priority over counting.
  always_comb begin
    branch_cnt_d = branch_cnt_q;
    mis_cnt_d    = mis_cnt_q;
    if (StatClear) begin
      branch_cnt_d = '0;
      mis_cnt_d    = '0;
    end else if (UpdateE) begin
      if (branch_cnt_q != {CNT_W{1'b1}}) branch_cnt_d = branch_cnt_q + CNT_W'(1);
      if (MispredictE && (mis_cnt_q != {CNT_W{1'b1}})) mis_cnt_d = mis_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branch_cnt_q <= '0;
      mis_cnt_q    <= '0;
    end else begin
      branch_cnt_q <= branch_cnt_d;
      mis_cnt_q    <= mis_cnt_d;
    end
  end

  assign BranchCount     = branch_cnt_q;
  assign MispredictCount = mis_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: lookup, counter hysteresis, aliasing, same-cycle
// read-before-write, performance counters (32-bit and 4-bit instances) and async reset.
module tb_branch_predictor;

  logic        clk;
  logic        rst;
  logic [31:0] PCF;
  logic        PredictTakenF;
  logic [31:0] PredictTargetF;
  logic        UpdateE;
  logic        JumpE;
  logic [31:0] PCE;
  logic        TakenE;
  logic [31:0] TargetE;
  logic        MispredictE;
  logic        StatClear;
  logic [31:0] BranchCount;
  logic [31:0] MispredictCount;

  logic        pt4;
  logic [31:0] ptg4;
  logic [3:0]  bc4;
  logic [3:0]  mc4;

  int checks = 0;
  int errors = 0;

  branch_predictor #(.IDX_BITS(4), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .PCF(PCF),
    .PredictTakenF(PredictTakenF), .PredictTargetF(PredictTargetF),
    .UpdateE(UpdateE), .JumpE(JumpE), .PCE(PCE), .TakenE(TakenE), .TargetE(TargetE),
    .MispredictE(MispredictE), .StatClear(StatClear),
    .BranchCount(BranchCount), .MispredictCount(MispredictCount)
  );

  branch_predictor #(.IDX_BITS(4), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .PCF(PCF),
    .PredictTakenF(pt4), .PredictTargetF(ptg4),
    .UpdateE(UpdateE), .JumpE(JumpE), .PCE(PCE), .TakenE(TakenE), .TargetE(TargetE),
    .MispredictE(MispredictE), .StatClear(StatClear),
    .BranchCount(bc4), .MispredictCount(mc4)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_update(input logic [31:0] pce, input logic taken, input logic [31:0] tgt,
                           input logic jump, input logic mis);
    UpdateE     = 1'b1;
    PCE         = pce;
    TakenE      = taken;
    TargetE     = tgt;
    JumpE       = jump;
    MispredictE = mis;
    tick();
    UpdateE     = 1'b0;
    JumpE       = 1'b0;
    TakenE      = 1'b0;
    MispredictE = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; PCF = 32'h100; UpdateE = 0; JumpE = 0; PCE = 0; TakenE = 0;
    TargetE = 0; MispredictE = 0; StatClear = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (PredictTakenF !== 1'b0) begin errors++; $display("FAIL reset_taken got %b exp 0", PredictTakenF); end
    checks++; if (PredictTargetF !== 32'h0) begin errors++; $display("FAIL reset_target got %h exp 0", PredictTargetF); end
    checks++; if (BranchCount !== 32'd0) begin errors++; $display("FAIL reset_bcount got %0d exp 0", BranchCount); end
    checks++; if (MispredictCount !== 32'd0) begin errors++; $display("FAIL reset_mcount got %0d exp 0", MispredictCount); end
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic test_predict();
    do_update(32'h100, 1'b1, 32'h80, 1'b0, 1'b0);
    PCF = 32'h100; #1;
    checks++; if (PredictTakenF !== 1'b1) begin errors++; $display("FAIL alloc_taken got %b exp 1", PredictTakenF); end
    checks++; if (PredictTargetF !== 32'h80) begin errors++; $display("FAIL alloc_target got %h exp 00000080", PredictTargetF); end
  endtask

  task automatic test_hysteresis();
    // Not-taken updates carry a junk target that must not be written.
    do_update(32'h100, 1'b0, 32'hDEAD, 1'b0, 1'b0);
    checks++; if (PredictTakenF !== 1'b0) begin errors++; $display("FAIL nt1_taken got %b exp 0", PredictTakenF); end
    checks++; if (PredictTargetF !== 32'h80) begin errors++; $display("FAIL nt1_target got %h exp 00000080", PredictTargetF); end
    do_update(32'h100, 1'b0, 32'hDEAD, 1'b0, 1'b0);
    do_update(32'h100, 1'b0, 32'hDEAD, 1'b0, 1'b0);
    do_update(32'h100, 1'b1, 32'h80, 1'b0, 1'b0);
    checks++; if (PredictTakenF !== 1'b0) begin errors++; $display("FAIL floor_01_taken got %b exp 0", PredictTakenF); end
    checks++; if (PredictTargetF !== 32'h80) begin errors++; $display("FAIL floor_target got %h exp 00000080", PredictTargetF); end
    do_update(32'h100, 1'b1, 32'h80, 1'b0, 1'b0);
    checks++; if (PredictTakenF !== 1'b1) begin errors++; $display("FAIL back_to_10_taken got %b exp 1", PredictTakenF); end
  endtask

  task automatic test_alias();
    do_update(32'h140, 1'b1, 32'h200, 1'b0, 1'b0);
    PCF = 32'h100; #1;
    checks++; if (PredictTakenF !== 1'b0) begin errors++; $display("FAIL alias_old_taken got %b exp 0", PredictTakenF); end
    checks++; if (PredictTargetF !== 32'h0) begin errors++; $display("FAIL alias_old_target got %h exp 0", PredictTargetF); end
    PCF = 32'h140; #1;
    checks++; if (PredictTakenF !== 1'b1) begin errors++; $display("FAIL alias_new_taken got %b exp 1", PredictTakenF); end
    checks++; if (PredictTargetF !== 32'h200) begin errors++; $display("FAIL alias_new_target got %h exp 00000200", PredictTargetF); end
    do_update(32'h140, 1'b0, 32'h0, 1'b0, 1'b0);
    checks++; if (PredictTakenF !== 1'b0) begin errors++; $display("FAIL alias_dec_taken got %b exp 0", PredictTakenF); end
    // Jump from 01 goes straight to 11, so one not-taken afterwards still predicts taken.
    do_update(32'h140, 1'b1, 32'h240, 1'b1, 1'b0);
    do_update(32'h140, 1'b0, 32'h0, 1'b0, 1'b0);
    checks++; if (PredictTakenF !== 1'b1) begin errors++; $display("FAIL jump_11_taken got %b exp 1", PredictTakenF); end
    checks++; if (PredictTargetF !== 32'h240) begin errors++; $display("FAIL jump_target got %h exp 00000240", PredictTargetF); end
    PCE = 32'h180; TakenE = 1'b1; TargetE = 32'h999; JumpE = 1'b1; UpdateE = 1'b0;
    tick();
    checks++; if (PredictTargetF !== 32'h240) begin errors++; $display("FAIL noupd_target got %h exp 00000240", PredictTargetF); end
    do_update(32'h204, 1'b0, 32'h444, 1'b0, 1'b0);
    PCF = 32'h204; #1;
    checks++; if (PredictTakenF !== 1'b0) begin errors++; $display("FAIL nt_noalloc_taken got %b exp 0", PredictTakenF); end
    checks++; if (PredictTargetF !== 32'h0) begin errors++; $display("FAIL nt_noalloc_target got %h exp 0", PredictTargetF); end
  endtask

  task automatic test_same_cycle();
    PCF = 32'h300; UpdateE = 1'b1; PCE = 32'h300; TakenE = 1'b1; TargetE = 32'h400; JumpE = 1'b0;
    #1;
    checks++; if (PredictTakenF !== 1'b0) begin errors++; $display("FAIL same_pre_taken got %b exp 0", PredictTakenF); end
    tick();
    UpdateE = 1'b0; TakenE = 1'b0;
    checks++; if (PredictTakenF !== 1'b1) begin errors++; $display("FAIL same_post_taken got %b exp 1", PredictTakenF); end
    checks++; if (PredictTargetF !== 32'h400) begin errors++; $display("FAIL same_post_target got %h exp 00000400", PredictTargetF); end
  endtask

  task automatic test_counters();
    StatClear = 1'b1; tick(); StatClear = 1'b0;
    checks++; if (BranchCount !== 32'd0) begin errors++; $display("FAIL clr_bcount got %0d exp 0", BranchCount); end
    for (int i = 0; i < 10; i++) do_update(32'h500, 1'b0, 32'h0, 1'b0, (i == 1 || i == 4 || i == 8));
    MispredictE = 1'b1; tick(); MispredictE = 1'b0;
    checks++; if (BranchCount !== 32'd10) begin errors++; $display("FAIL cnt_bcount got %0d exp 10", BranchCount); end
    checks++; if (MispredictCount !== 32'd3) begin errors++; $display("FAIL cnt_mcount got %0d exp 3", MispredictCount); end
    StatClear = 1'b1;
    do_update(32'h500, 1'b0, 32'h0, 1'b0, 1'b1);
    StatClear = 1'b0;
    checks++; if (BranchCount !== 32'd0) begin errors++; $display("FAIL clrwin_bcount got %0d exp 0", BranchCount); end
    checks++; if (MispredictCount !== 32'd0) begin errors++; $display("FAIL clrwin_mcount got %0d exp 0", MispredictCount); end
    for (int i = 0; i < 20; i++) do_update(32'h500, 1'b0, 32'h0, 1'b0, 1'b1);
    checks++; if (BranchCount !== 32'd20) begin errors++; $display("FAIL wide_bcount got %0d exp 20", BranchCount); end
    checks++; if (bc4 !== 4'd15) begin errors++; $display("FAIL sat_bcount got %0d exp 15", bc4); end
    checks++; if (mc4 !== 4'd15) begin errors++; $display("FAIL sat_mcount got %0d exp 15", mc4); end
  endtask

  task automatic test_async_reset();
    PCF = 32'h300;
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (PredictTakenF !== 1'b0) begin errors++; $display("FAIL arst_taken got %b exp 0", PredictTakenF); end
    checks++; if (BranchCount !== 32'd0) begin errors++; $display("FAIL arst_bcount got %0d exp 0", BranchCount); end
    checks++; if (mc4 !== 4'd0) begin errors++; $display("FAIL arst_mcount4 got %0d exp 0", mc4); end
    UpdateE = 1'b1; PCE = 32'h300; TakenE = 1'b1; TargetE = 32'h600; JumpE = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (PredictTakenF !== 1'b0) begin errors++; $display("FAIL arst_held_taken got %b exp 0", PredictTakenF); end
    tick();
    UpdateE = 1'b0; TakenE = 1'b0;
    checks++; if (PredictTargetF !== 32'h600) begin errors++; $display("FAIL arst_first_target got %h exp 00000600", PredictTargetF); end
    checks++; if (BranchCount !== 32'd1) begin errors++; $display("FAIL arst_first_bcount got %0d exp 1", BranchCount); end
  endtask

  initial begin
    test_reset();
    test_predict();
    test_hysteresis();
    test_alias();
    test_same_cycle();
    test_counters();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
